// File: rtl/pll_lock_supervisor_if.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_supervisor_if
// Description : Per-channel PLL control/status bundle between the supervisor
//               (slave) and the PLL wrapper / reset logic side (master).
// Revision    : 1.0 - initial release
// ============================================================================
interface pll_lock_supervisor_if #(
    parameter int N_PLL = 4,
    parameter int CNT_W = 16
);
    logic [N_PLL-1:0]       pll_locked_in;
    logic [N_PLL-1:0]       pll_enable;
    logic [N_PLL-1:0]       clear_fault;
    logic [N_PLL-1:0]       pll_rst_out;
    logic [N_PLL-1:0]       ch_locked;
    logic [N_PLL-1:0]       ch_fault;
    logic                   all_locked;
    logic [N_PLL*CNT_W-1:0] loss_cnt;

    modport master (
        output pll_locked_in, pll_enable, clear_fault,
        input  pll_rst_out, ch_locked, ch_fault, all_locked, loss_cnt
    );

    modport slave (
        input  pll_locked_in, pll_enable, clear_fault,
        output pll_rst_out, ch_locked, ch_fault, all_locked, loss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Resets N_PLL PLLs, qualifies lock over a stability window,
//               retries on timeout and faults after repeated failures.
//               Define PLL_SUP_LOSS_CNT_EN to build the loss-of-lock counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int N_PLL        = 4,
    parameter int RESET_PULSE  = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 1024,
    parameter int RETRY_LIMIT  = 8,
    parameter int CNT_W        = 16
) (
    input  logic                 refclk,
    input  logic                 rst,
    pll_lock_supervisor_if.slave bus
);

    localparam int c_T_MAX0 = (RESET_PULSE > LOCK_TIMEOUT) ? RESET_PULSE : LOCK_TIMEOUT;
    localparam int c_T_MAX  = (c_T_MAX0 > LOCK_STABLE) ? c_T_MAX0 : LOCK_STABLE;
    localparam int c_TMR_W  = (c_T_MAX > 1) ? $clog2(c_T_MAX) : 1;
    localparam int c_RTY_W  = $clog2(RETRY_LIMIT + 1);

    localparam logic [c_TMR_W-1:0] c_RP_LAST = c_TMR_W'(RESET_PULSE - 1);
    localparam logic [c_TMR_W-1:0] c_TO_LAST = c_TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_ST_LAST = c_TMR_W'(LOCK_STABLE - 1);
    localparam logic [c_RTY_W-1:0] c_RTY_LIM = c_RTY_W'(RETRY_LIMIT);

    localparam logic [2:0] c_ST_RST    = 3'd0;
    localparam logic [2:0] c_ST_WAIT   = 3'd1;
    localparam logic [2:0] c_ST_STABLE = 3'd2;
    localparam logic [2:0] c_ST_LOCKED = 3'd3;
    localparam logic [2:0] c_ST_FAULT  = 3'd4;

    logic [N_PLL-1:0] r_sync1;
    logic [N_PLL-1:0] r_locked_s;
    logic [N_PLL-1:0] w_ch_locked;
    logic             r_all_locked;

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_sync1    <= '0;
            r_locked_s <= '0;
        end else begin
            r_sync1    <= bus.pll_locked_in;
            r_locked_s <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < N_PLL; gi++) begin : g_ch
        logic [2:0]         r_state;
        logic [2:0]         w_state_nxt;
        logic [c_TMR_W-1:0] r_timer;
        logic [c_TMR_W-1:0] w_timer_nxt;
        logic [c_RTY_W-1:0] r_retry;
        logic [c_RTY_W-1:0] w_retry_nxt;
        logic [c_RTY_W-1:0] w_retry_inc;
        logic               r_rst_out;
        logic               r_locked;
        logic               r_fault;

        always_comb begin
            w_state_nxt = r_state;
            w_timer_nxt = r_timer;
            w_retry_nxt = r_retry;
            w_retry_inc = r_retry + 1'b1;
            // A disabled channel is parked in reset regardless of anything else
            if (!bus.pll_enable[gi]) begin
                w_state_nxt = c_ST_RST;
                w_timer_nxt = '0;
                w_retry_nxt = '0;
            end else begin
                case (r_state)
                    c_ST_RST: begin
                        if (r_timer == c_RP_LAST) begin
                            w_state_nxt = c_ST_WAIT;
                            w_timer_nxt = '0;
                        end else begin
                            w_timer_nxt = r_timer + 1'b1;
                        end
                    end
                    c_ST_WAIT: begin
                        if (r_locked_s[gi]) begin
                            w_state_nxt = c_ST_STABLE;
                            w_timer_nxt = '0;
                        end else if (r_timer == c_TO_LAST) begin
                            w_retry_nxt = w_retry_inc;
                            w_timer_nxt = '0;
                            w_state_nxt = (w_retry_inc == c_RTY_LIM) ? c_ST_FAULT : c_ST_RST;
                        end else begin
                            w_timer_nxt = r_timer + 1'b1;
                        end
                    end
                    c_ST_STABLE: begin
                        if (!r_locked_s[gi]) begin
                            w_state_nxt = c_ST_WAIT;
                            w_timer_nxt = '0;
                        end else if (r_timer == c_ST_LAST) begin
                            w_state_nxt = c_ST_LOCKED;
                            w_timer_nxt = '0;
                            w_retry_nxt = '0;
                        end else begin
                            w_timer_nxt = r_timer + 1'b1;
                        end
                    end
                    c_ST_LOCKED: begin
                        if (!r_locked_s[gi]) begin
                            w_state_nxt = c_ST_RST;
                            w_timer_nxt = '0;
                        end
                    end
                    c_ST_FAULT: begin
                        if (bus.clear_fault[gi]) begin
                            w_state_nxt = c_ST_RST;
                            w_timer_nxt = '0;
                            w_retry_nxt = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = c_ST_RST;
                        w_timer_nxt = '0;
                        w_retry_nxt = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge refclk) begin
            if (rst) begin
                r_state   <= c_ST_RST;
                r_timer   <= '0;
                r_retry   <= '0;
                r_rst_out <= 1'b1;
                r_locked  <= 1'b0;
                r_fault   <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_timer   <= w_timer_nxt;
                r_retry   <= w_retry_nxt;
                r_rst_out <= (w_state_nxt == c_ST_RST) || (w_state_nxt == c_ST_FAULT);
                r_locked  <= (w_state_nxt == c_ST_LOCKED);
                r_fault   <= (w_state_nxt == c_ST_FAULT);
            end
        end

        assign bus.pll_rst_out[gi] = r_rst_out;
        assign bus.ch_fault[gi]    = r_fault;
        assign w_ch_locked[gi]     = r_locked;

`ifdef PLL_SUP_LOSS_CNT_EN
        logic               w_loss_evt;
        logic [CNT_W-1:0]   r_loss;

        assign w_loss_evt = bus.pll_enable[gi] && (r_state == c_ST_LOCKED) && !r_locked_s[gi];

        always_ff @(posedge refclk) begin
            if (rst) begin
                r_loss <= '0;
            end else if (w_loss_evt && (r_loss != {CNT_W{1'b1}})) begin
                r_loss <= r_loss + 1'b1;
            end
        end

        assign bus.loss_cnt[gi*CNT_W +: CNT_W] = r_loss;
`else
        assign bus.loss_cnt[gi*CNT_W +: CNT_W] = '0;
`endif
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_all_locked <= 1'b0;
        end else begin
            r_all_locked <= (|bus.pll_enable) && (&(w_ch_locked | ~bus.pll_enable));
        end
    end

    assign bus.ch_locked  = w_ch_locked;
    assign bus.all_locked = r_all_locked;

endmodule
`default_nettype wire
